// File: rtl/spi_move_slave.sv
// SPI mode-0 responder: receives 8-bit move frames and returns a status byte in the same frame.
// Optional even-parity check on bit 7 is built only when SPI_MOVE_PARITY_EN is defined.
module spi_move_slave #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned MAX_INDEX   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_sclk,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic       spi_miso_oe,
   input  logic [7:0] tx_status,
   output logic [4:0] move_index,
   output logic       move_valid,
   output logic       frame_err,
   output logic       busy
);

`ifdef SPI_MOVE_PARITY_EN
   localparam int unsigned RxW = 8;
`else
   // Without parity the first (parity) bit simply falls off the top of the shifter.
   localparam int unsigned RxW = 7;
`endif
   localparam int unsigned FlushCycles = SYNC_STAGES + 1;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic                   sclk_prev_q, cs_prev_q;
   logic                   sclk_s, cs_s, mosi_s;
   logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

   logic [2:0]             flush_cnt_q;
   logic                   flush_done;
   logic                   armed_q;

   state_e                 state_q, state_d;
   logic [3:0]             bit_cnt_q, bit_cnt_d;
   logic                   overrun_q, overrun_d;
   logic [RxW-1:0]         rx_sr_q, rx_sr_d;
   logic [7:0]             tx_sr_q, tx_sr_d;
   logic                   miso_q, miso_d;
   logic [4:0]             move_index_q, move_index_d;
   logic                   move_valid_q, move_valid_d;
   logic                   frame_err_q, frame_err_d;

   logic                   idx_ok, cmd_ok, parity_ok, frame_good;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;
   assign cs_rise   = cs_s & ~cs_prev_q;

   // A frame already running when reset releases must be skipped: only arm once the
   // synchronizers have flushed and cs_n is seen high.
   assign flush_done = (flush_cnt_q == 3'(FlushCycles));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_cnt_q <= '0;
         armed_q     <= 1'b0;
      end else begin
         if (!flush_done) flush_cnt_q <= flush_cnt_q + 3'd1;
         if (flush_done && cs_s) armed_q <= 1'b1;
      end
   end

   assign idx_ok = (32'(rx_sr_q[4:0]) <= MAX_INDEX);
   assign cmd_ok = (rx_sr_q[6:5] == 2'b01);
`ifdef SPI_MOVE_PARITY_EN
   assign parity_ok = ~^rx_sr_q;
`else
   assign parity_ok = 1'b1;
`endif
   assign frame_good = (bit_cnt_q == 4'd8) && !overrun_q && cmd_ok && idx_ok && parity_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         bit_cnt_q    <= '0;
         overrun_q    <= 1'b0;
         rx_sr_q      <= '0;
         tx_sr_q      <= '0;
         miso_q       <= 1'b0;
         move_index_q <= '0;
         move_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         overrun_q    <= overrun_d;
         rx_sr_q      <= rx_sr_d;
         tx_sr_q      <= tx_sr_d;
         miso_q       <= miso_d;
         move_index_q <= move_index_d;
         move_valid_q <= move_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      overrun_d    = overrun_q;
      rx_sr_d      = rx_sr_q;
      tx_sr_d      = tx_sr_q;
      miso_d       = miso_q;
      move_index_d = move_index_q;
      move_valid_d = 1'b0;
      frame_err_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            // sclk edges here are ignored, including one coinciding with cs_fall.
            if (cs_fall && armed_q) begin
               state_d   = StShift;
               tx_sr_d   = tx_status;
               miso_d    = tx_status[7];
               bit_cnt_d = '0;
               overrun_d = 1'b0;
               rx_sr_d   = '0;
            end
         end
         StShift: begin
            if (cs_rise) begin
               state_d = StDone;
               miso_d  = 1'b0;
               if (frame_good) begin
                  move_valid_d = 1'b1;
                  move_index_d = rx_sr_q[4:0];
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               if (sclk_rise) begin
                  if (bit_cnt_q < 4'd8) begin
                     rx_sr_d   = {rx_sr_q[RxW-2:0], mosi_s};
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end
               if (sclk_fall) begin
                  tx_sr_d = {tx_sr_q[6:0], 1'b0};
                  miso_d  = tx_sr_q[6];
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign busy        = (state_q == StShift);
   assign spi_miso_oe = (state_q == StShift);
   assign spi_miso    = miso_q;
   assign move_index  = move_index_q;
   assign move_valid  = move_valid_q;
   assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_move_slave.sv
// Scoreboard bench for spi_move_slave: directed and random SPI frames against a frame-level model.
module tb_spi_move_slave;

   localparam int unsigned SYNC  = 2;
   localparam int unsigned MAXI  = 8;
   localparam int          HALF  = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic       spi_sclk, spi_cs_n, spi_mosi;
   logic       spi_miso, spi_miso_oe;
   logic [7:0] tx_status;
   logic [4:0] move_index;
   logic       move_valid, frame_err, busy;

   typedef struct {
      logic       good;
      logic [4:0] idx;
      int         cyc;
   } exp_t;

   exp_t       sb_q[$];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   logic [4:0] model_idx = 5'd0;

   spi_move_slave #(
      .SYNC_STAGES(SYNC),
      .MAX_INDEX  (MAXI)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .spi_sclk   (spi_sclk),
      .spi_cs_n   (spi_cs_n),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso),
      .spi_miso_oe(spi_miso_oe),
      .tx_status  (tx_status),
      .move_index (move_index),
      .move_valid (move_valid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Frame-level reference: what the controller sent decides the outcome.
   function automatic logic frame_good(input logic [7:0] d, input int n);
      logic ok;
      ok = (n == 8) && (d[6:5] == 2'b01) && (int'(d[4:0]) <= int'(MAXI));
`ifdef SPI_MOVE_PARITY_EN
      ok = ok && ((^d) == 1'b0);
`endif
      return ok;
   endfunction

   task automatic sclk_bit(input logic b, input logic exp_miso, input string tag);
      spi_mosi = b;
      tick(HALF);
      check(tag, 32'(spi_miso), 32'(exp_miso));
      spi_sclk = 1'b1;
      tick(HALF);
      spi_sclk = 1'b0;
   endtask

   task automatic frame(input logic [7:0] data, input int nbits, input logic [7:0] st,
                        input bit mid_change);
      exp_t e;
      logic b, em;
      tx_status = st;
      tick(1);
      spi_cs_n = 1'b0;
      tick(6);
      check("busy_in_frame", 32'(busy), 32'd1);
      check("oe_in_frame", 32'(spi_miso_oe), 32'd1);
      if (mid_change) tx_status = ~st;
      for (int i = 0; i < nbits; i++) begin
         b  = (i < 8) ? data[7-i] : 1'($urandom_range(0, 1));
         em = (i < 8) ? st[7-i] : 1'b0;
         sclk_bit(b, em, $sformatf("miso_bit%0d_st%02h", i, st));
      end
      tick(HALF);
      spi_cs_n = 1'b1;
      e.good = frame_good(data, nbits);
      if (e.good) model_idx = data[4:0];
      e.idx = model_idx;
      e.cyc = cyc + int'(SYNC) + 1;
      sb_q.push_back(e);
      tick(2);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (sb_q.size() != 0 && n < 20) begin
         tick(1);
         n++;
      end
      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL %s: missing pulse, got none expected %0d", tag, sb_q.size());
         sb_q.delete();
      end
      tick(6);
   endtask

   task automatic idle_sclk(input int n);
      for (int i = 0; i < n; i++) begin
         spi_sclk = 1'b1;
         tick(HALF);
         spi_sclk = 1'b0;
         tick(HALF);
      end
   endtask

   // Monitor: every pulse must match the oldest outstanding expectation, on the exact cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (move_valid && frame_err) check("pulses_exclusive", 32'd1, 32'd0);
         if (move_valid || frame_err) begin
            if (sb_q.size() == 0) begin
               check("unexpected_pulse", {30'd0, move_valid, frame_err}, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("pulse_kind", 32'(move_valid), 32'(e.good));
               check("pulse_index", 32'(move_index), 32'(e.idx));
               check("pulse_cycle", 32'(cyc), 32'(e.cyc));
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      int         nb, r;
      rst       = 1'b1;
      spi_sclk  = 1'b0;
      spi_cs_n  = 1'b1;
      spi_mosi  = 1'b0;
      tx_status = 8'h00;
      tick(3);
      check("rst_valid", 32'(move_valid), 32'd0);
      check("rst_err", 32'(frame_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_oe", 32'(spi_miso_oe), 32'd0);
      check("rst_miso", 32'(spi_miso), 32'd0);
      check("rst_index", 32'(move_index), 32'd0);
      rst = 1'b0;
      tick(10);
      check("idle_busy", 32'(busy), 32'd0);

      frame(8'h23, 8, 8'hA5, 1'b0);
      drain("good_23");
      frame(8'h29, 8, 8'h3C, 1'b0);
      drain("idx_9");
      frame(8'h20, 5, 8'h81, 1'b0);
      drain("short_5");
      frame(8'h20, 8, 8'h5A, 1'b0);
      drain("good_20");
      frame(8'h23, 9, 8'hC3, 1'b0);
      drain("overrun_9");
      frame(8'h22, 0, 8'h11, 1'b0);
      drain("zero_bits");
      frame(8'h43, 8, 8'h00, 1'b0);
      drain("bad_cmd");
      idle_sclk(3);
      frame(8'h28, 8, 8'hF0, 1'b1);
      drain("idx_8_midchange");
      frame(8'hA3, 8, 8'h96, 1'b0);
      drain("parity_a3");

      // Reset mid-frame, then finish that frame after release: it must be ignored.
      tx_status = 8'h5A;
      tick(1);
      spi_cs_n = 1'b0;
      tick(6);
      for (int i = 0; i < 4; i++) sclk_bit(1'b1, tx_status[7-i], $sformatf("rst_miso_bit%0d", i));
      rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_oe", 32'(spi_miso_oe), 32'd0);
      check("midrst_valid", 32'(move_valid), 32'd0);
      check("midrst_err", 32'(frame_err), 32'd0);
      model_idx = 5'd0;
      tick(2);
      rst = 1'b0;
      check("postrst_index", 32'(move_index), 32'd0);
      idle_sclk(4);
      spi_cs_n = 1'b1;
      tick(20);
      check("ignored_frame_busy", 32'(busy), 32'd0);
      frame(8'h21, 8, 8'h7E, 1'b0);
      drain("good_after_rst");

      for (int k = 0; k < 40; k++) begin
         r  = $urandom_range(0, 9);
         nb = (r < 7) ? 8 : $urandom_range(0, 9);
         d[7]   = 1'($urandom_range(0, 1));
         d[6:5] = ($urandom_range(0, 4) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
         d[4:0] = 5'($urandom_range(0, 11));
         frame(d, nb, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         drain($sformatf("rand%0d_%02h_n%0d", k, d, nb));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
